// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings and types for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic stall;
        logic noop;
        logic flush;
        logic freeze;
    } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_o <= '0;
        else if (inc_i && (cnt_o != {CNT_W{1'b1}}))
            cnt_o <= cnt_o + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges memory-wait freeze, load-use bubble and branch flush.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic [4:0]       RDaddr_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic             Branch_i,
    input  logic             DmemReq_i,
    input  logic             DmemAck_i,
    output logic             PCWrite_o,
    output logic             Stall_o,
    output logic             NoOp_o,
    output logic             Flush_o,
    output logic             Freeze_o,
    output logic             Error_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] LoadUseCnt_o
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              error_q;
    logic              memstall, loaduse;
    ctrl_t             ctrl;

    assign memstall = ((state_q == ST_RUN) && DmemReq_i && !DmemAck_i)
                    || ((state_q == ST_MEM_WAIT) && !DmemAck_i)
                    || (state_q == ST_ERROR);

    // RDaddr_i != x0 also rules out a match on an x0 source operand.
    assign loaduse = MemRead_i && (RDaddr_i != REG_ZERO)
                   && ((RDaddr_i == RS1addr_i) || (RDaddr_i == RS2addr_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_q || (state_d == ST_ERROR);
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (DmemReq_i && !DmemAck_i) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (DmemAck_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // A pending branch is dropped under a stall; it replays or re-resolves next cycle.
    always_comb begin
        ctrl          = '0;
        ctrl.pc_write = 1'b1;
        if (memstall) begin
            ctrl.pc_write = 1'b0;
            ctrl.stall    = 1'b1;
            ctrl.freeze   = 1'b1;
        end else if (loaduse) begin
            ctrl.pc_write = 1'b0;
            ctrl.stall    = 1'b1;
            ctrl.noop     = 1'b1;
        end else if (Branch_i) begin
            ctrl.flush    = 1'b1;
        end
    end

    assign PCWrite_o = ctrl.pc_write;
    assign Stall_o   = ctrl.stall;
    assign NoOp_o    = ctrl.noop;
    assign Flush_o   = ctrl.flush;
    assign Freeze_o  = ctrl.freeze;
    assign Error_o   = error_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ctrl.stall || ctrl.freeze),
        .cnt_o (StallCnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (loaduse && !memstall),
        .cnt_o (LoadUseCnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: default instance plus a small one (timeout 4, 3-bit counters).
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst, memread, br, req, ack;
    logic [4:0] rd, rs1, rs2;

    logic pcw_a, stall_a, noop_a, flush_a, freeze_a, err_a;
    logic pcw_b, stall_b, noop_b, flush_b, freeze_b, err_b;
    logic [15:0] sc_a, lu_a;
    logic [2:0]  sc_b, lu_b;
    logic [5:0]  oa, ob;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state, index 0 = default instance, 1 = small instance
    int m_n[2], m_sc[2], m_lu[2];
    bit m_err[2];
    int m_to[2]   = '{64, 4};
    int m_cmax[2] = '{65535, 7};

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .MemRead_i(memread), .RDaddr_i(rd),
        .RS1addr_i(rs1), .RS2addr_i(rs2), .Branch_i(br), .DmemReq_i(req),
        .DmemAck_i(ack), .PCWrite_o(pcw_a), .Stall_o(stall_a), .NoOp_o(noop_a),
        .Flush_o(flush_a), .Freeze_o(freeze_a), .Error_o(err_a),
        .StallCnt_o(sc_a), .LoadUseCnt_o(lu_a)
    );

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .MemRead_i(memread), .RDaddr_i(rd),
        .RS1addr_i(rs1), .RS2addr_i(rs2), .Branch_i(br), .DmemReq_i(req),
        .DmemAck_i(ack), .PCWrite_o(pcw_b), .Stall_o(stall_b), .NoOp_o(noop_b),
        .Flush_o(flush_b), .Freeze_o(freeze_b), .Error_o(err_b),
        .StallCnt_o(sc_b), .LoadUseCnt_o(lu_b)
    );

    // {PCWrite, Stall, NoOp, Flush, Freeze, Error}
    assign oa = {pcw_a, stall_a, noop_a, flush_a, freeze_a, err_a};
    assign ob = {pcw_b, stall_b, noop_b, flush_b, freeze_b, err_b};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic b, input logic rq, input logic ak);
        memread = mr; rd = d; rs1 = s1; rs2 = s2; br = b; req = rq; ack = ak;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL reset_out_a got %b want %b", oa, 6'b100000); end
        n_cmp++; if (ob !== 6'b100000) begin n_bad++; $display("FAIL reset_out_b got %b want %b", ob, 6'b100000); end
        n_cmp++; if ({sc_a, lu_a} !== 32'd0) begin n_bad++; $display("FAIL reset_cnt_a got %0d/%0d want 0/0", sc_a, lu_a); end
        n_cmp++; if ({sc_b, lu_b} !== 6'd0) begin n_bad++; $display("FAIL reset_cnt_b got %0d/%0d want 0/0", sc_b, lu_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 5, 5, 0, 0, 0, 0);
        n_cmp++; if (oa !== 6'b011000) begin n_bad++; $display("FAIL lu_rs1 got %b want %b", oa, 6'b011000); end
        step();
        n_cmp++; if (lu_a !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", lu_a); end
        drive(1, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL lu_x0 got %b want %b", oa, 6'b100000); end
        drive(1, 7, 3, 7, 0, 0, 0);
        n_cmp++; if (ob !== 6'b011000) begin n_bad++; $display("FAIL lu_rs2 got %b want %b", ob, 6'b011000); end
        drive(0, 7, 7, 7, 0, 0, 0);
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL lu_noload got %b want %b", oa, 6'b100000); end
    endtask

    task automatic test_mem_wait();
        int frz;
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL mem_reqack got %b want %b", oa, 6'b100000); end
        step();
        frz = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            if (freeze_a === 1'b1) frz++;
            step();
        end
        n_cmp++; if (frz != 3) begin n_bad++; $display("FAIL mem_freeze_cycles got %0d want 3", frz); end
        drive(0, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL mem_ack_cycle got %b want %b", oa, 6'b100000); end
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (sc_a !== 16'd3) begin n_bad++; $display("FAIL mem_stallcnt got %0d want 3", sc_a); end
        n_cmp++; if (ob !== 6'b100000) begin n_bad++; $display("FAIL mem_back_run got %b want %b", ob, 6'b100000); end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 9, 9, 0, 1, 1, 0);
        n_cmp++; if (oa !== 6'b010010) begin n_bad++; $display("FAIL prio_freeze got %b want %b", oa, 6'b010010); end
        step();
        drive(1, 9, 9, 0, 1, 1, 1);
        n_cmp++; if (oa !== 6'b011000) begin n_bad++; $display("FAIL prio_loaduse got %b want %b", oa, 6'b011000); end
        step();
        drive(0, 9, 9, 0, 1, 0, 0);
        n_cmp++; if (oa !== 6'b100100) begin n_bad++; $display("FAIL prio_branch got %b want %b", oa, 6'b100100); end
        n_cmp++; if (lu_a !== 16'd1) begin n_bad++; $display("FAIL prio_lucnt got %0d want 1", lu_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (err_b !== (i == 3)) begin n_bad++; $display("FAIL timeout_edge%0d got %b want %b", i + 1, err_b, i == 3); end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (ob !== 6'b010011) begin n_bad++; $display("FAIL timeout_held got %b want %b", ob, 6'b010011); end
        n_cmp++; if (oa !== 6'b100000) begin n_bad++; $display("FAIL timeout_a_ack got %b want %b", oa, 6'b100000); end
        step();
        n_cmp++; if (ob !== 6'b010011) begin n_bad++; $display("FAIL timeout_sticky got %b want %b", ob, 6'b010011); end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (ob !== 6'b100000) begin n_bad++; $display("FAIL timeout_rst got %b want %b", ob, 6'b100000); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 4, 4, 4, 0, 0, 0);
        for (int i = 0; i < 9; i++) step();
        n_cmp++; if (sc_b !== 3'd7) begin n_bad++; $display("FAIL sat_stall_b got %0d want 7", sc_b); end
        n_cmp++; if (lu_b !== 3'd7) begin n_bad++; $display("FAIL sat_lu_b got %0d want 7", lu_b); end
        n_cmp++; if (sc_a !== 16'd9) begin n_bad++; $display("FAIL sat_stall_a got %0d want 9", sc_a); end
    endtask

    task automatic test_random();
        bit lu, ms, busy;
        logic [5:0] exp_o;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_sc[k] = 0; m_lu[k] = 0; m_err[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
            for (int k = 0; k < 2; k++) begin
                busy  = (m_n[k] > 0) || req;
                ms    = m_err[k] || (busy && !ack);
                exp_o = {!(ms || lu), ms || lu, lu && !ms, br && !ms && !lu, ms, m_err[k]};
                n_cmp++;
                if ((k == 0 ? oa : ob) !== exp_o) begin
                    n_bad++; $display("FAIL rand_out%0d cyc %0d got %b want %b", k, c, (k == 0 ? oa : ob), exp_o);
                end
                n_cmp++;
                if ((k == 0 ? int'(sc_a) : int'(sc_b)) != m_sc[k] || (k == 0 ? int'(lu_a) : int'(lu_b)) != m_lu[k]) begin
                    n_bad++;
                    $display("FAIL rand_cnt%0d cyc %0d got %0d/%0d want %0d/%0d", k, c,
                             (k == 0 ? int'(sc_a) : int'(sc_b)), (k == 0 ? int'(lu_a) : int'(lu_b)), m_sc[k], m_lu[k]);
                end
                if (rst) begin
                    m_n[k] = 0; m_sc[k] = 0; m_lu[k] = 0; m_err[k] = 0;
                end else begin
                    if ((ms || lu) && m_sc[k] < m_cmax[k]) m_sc[k]++;
                    if (lu && !ms && m_lu[k] < m_cmax[k]) m_lu[k]++;
                    // an access outstanding for MEM_TIMEOUT unacked cycles is fatal
                    if (!m_err[k]) begin
                        if (busy && !ack) begin
                            m_n[k]++;
                            if (m_n[k] >= m_to[k]) m_err[k] = 1;
                        end else begin
                            m_n[k] = 0;
                        end
                    end
                end
            end
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
